// File: rtl/i2c_reg_slave.sv
// I2C register-access slave: device address match, 8-bit register pointer,
// burst writes and reads with pointer auto-increment, all on the system clock.
module i2c_reg_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   typedef enum logic [3:0] {
      IDLE, DEV_ADDR, DEV_ACK, REG_PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
   } state_t;

   logic [1:0] r_sclSync, r_sdaSync;
   logic       r_sclPrev, r_sdaPrev;
   logic       w_scl, w_sda, w_sclRise, w_sclFall, w_start, w_stop;
   logic [7:0] w_rxByte;

   state_t     r_state, w_nState;
   logic [3:0] r_bitCnt, w_nBitCnt;
   logic [7:0] r_shift, w_nShift;
   logic       r_sdaOe, w_nSdaOe;
   logic       r_ackPhase, w_nAckPhase;
   logic       r_busy, w_nBusy;
   logic       r_rw, w_nRw;
   logic [7:0] r_ptr, w_nPtr;
   logic [7:0] r_wdata, w_nWdata;
   logic       r_wr, w_nWr;

   // Idle bus is high, so synchronizers come out of reset at 1 to avoid false edges
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sclSync <= 2'b11;
         r_sdaSync <= 2'b11;
         r_sclPrev <= 1'b1;
         r_sdaPrev <= 1'b1;
      end else begin
         r_sclSync <= {r_sclSync[0], scl_in};
         r_sdaSync <= {r_sdaSync[0], sda_in};
         r_sclPrev <= r_sclSync[1];
         r_sdaPrev <= r_sdaSync[1];
      end
   end

   assign w_scl     = r_sclSync[1];
   assign w_sda     = r_sdaSync[1];
   assign w_sclRise = w_scl & ~r_sclPrev;
   assign w_sclFall = ~w_scl & r_sclPrev;
   assign w_start   = w_scl & r_sdaPrev & ~w_sda;
   assign w_stop    = w_scl & ~r_sdaPrev & w_sda;
   assign w_rxByte  = {r_shift[6:0], w_sda};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_bitCnt   <= 4'd0;
         r_shift    <= 8'h00;
         r_sdaOe    <= 1'b0;
         r_ackPhase <= 1'b0;
         r_busy     <= 1'b0;
         r_rw       <= 1'b0;
         r_ptr      <= 8'h00;
         r_wdata    <= 8'h00;
         r_wr       <= 1'b0;
      end else begin
         r_state    <= w_nState;
         r_bitCnt   <= w_nBitCnt;
         r_shift    <= w_nShift;
         r_sdaOe    <= w_nSdaOe;
         r_ackPhase <= w_nAckPhase;
         r_busy     <= w_nBusy;
         r_rw       <= w_nRw;
         r_ptr      <= w_nPtr;
         r_wdata    <= w_nWdata;
         r_wr       <= w_nWr;
      end
   end

   // START/STOP outrank SCL edges; the pointer bumps the clk after each write strobe
   always_comb begin
      w_nState    = r_state;
      w_nBitCnt   = r_bitCnt;
      w_nShift    = r_shift;
      w_nSdaOe    = r_sdaOe;
      w_nAckPhase = r_ackPhase;
      w_nBusy     = r_busy;
      w_nRw       = r_rw;
      w_nPtr      = r_wr ? r_ptr + 8'd1 : r_ptr;
      w_nWdata    = r_wdata;
      w_nWr       = 1'b0;
      if (w_stop) begin
         w_nState    = IDLE;
         w_nSdaOe    = 1'b0;
         w_nBusy     = 1'b0;
         w_nBitCnt   = 4'd0;
         w_nAckPhase = 1'b0;
      end else if (w_start) begin
         w_nState    = DEV_ADDR;
         w_nSdaOe    = 1'b0;
         w_nBitCnt   = 4'd0;
         w_nAckPhase = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
            end
            DEV_ADDR, REG_PTR, WR_DATA: begin
               if (w_sclRise) begin
                  w_nShift  = w_rxByte;
                  w_nBitCnt = r_bitCnt + 4'd1;
                  if (r_bitCnt == 4'd7) begin
                     w_nBitCnt   = 4'd0;
                     w_nAckPhase = 1'b0;
                     if (r_state == DEV_ADDR) begin
                        if (w_rxByte[7:1] == SLAVE_ADDR) begin
                           w_nBusy  = 1'b1;
                           w_nRw    = w_rxByte[0];
                           w_nState = DEV_ACK;
                        end else begin
                           w_nBusy  = 1'b0;
                           w_nState = IDLE;
                        end
                     end else if (r_state == REG_PTR) begin
                        w_nPtr   = w_rxByte;
                        w_nState = PTR_ACK;
                     end else begin
                        w_nWdata = w_rxByte;
                        w_nWr    = 1'b1;
                        w_nState = WR_ACK;
                     end
                  end
               end
            end
            DEV_ACK, PTR_ACK, WR_ACK: begin
               if (w_sclFall) begin
                  if (!r_ackPhase) begin
                     w_nSdaOe    = 1'b1;
                     w_nAckPhase = 1'b1;
                  end else begin
                     w_nAckPhase = 1'b0;
                     w_nSdaOe    = 1'b0;
                     w_nBitCnt   = 4'd0;
                     if (r_state == DEV_ACK && r_rw) begin
                        w_nShift = reg_rdata;
                        w_nSdaOe = ~reg_rdata[7];
                        w_nState = RD_DATA;
                     end else if (r_state == DEV_ACK) begin
                        w_nState = REG_PTR;
                     end else begin
                        w_nState = WR_DATA;
                     end
                  end
               end
            end
            RD_DATA: begin
               if (w_sclRise) begin
                  w_nBitCnt = r_bitCnt + 4'd1;
               end else if (w_sclFall) begin
                  if (r_bitCnt == 4'd8) begin
                     w_nSdaOe    = 1'b0;
                     w_nBitCnt   = 4'd0;
                     w_nAckPhase = 1'b0;
                     w_nState    = RD_ACK;
                  end else begin
                     w_nShift = {r_shift[6:0], 1'b0};
                     w_nSdaOe = ~r_shift[6];
                  end
               end
            end
            RD_ACK: begin
               if (w_sclRise && !r_ackPhase) begin
                  if (w_sda) begin
                     w_nState = IDLE;
                     w_nBusy  = 1'b0;
                     w_nSdaOe = 1'b0;
                  end else begin
                     w_nPtr      = r_ptr + 8'd1;
                     w_nAckPhase = 1'b1;
                  end
               end else if (w_sclFall && r_ackPhase) begin
                  w_nShift    = reg_rdata;
                  w_nSdaOe    = ~reg_rdata[7];
                  w_nAckPhase = 1'b0;
                  w_nBitCnt   = 4'd0;
                  w_nState    = RD_DATA;
               end
            end
            default: begin
               w_nState = IDLE;
            end
         endcase
      end
   end

   assign sda_oe    = r_sdaOe;
   assign reg_addr  = r_ptr;
   assign reg_wdata = r_wdata;
   assign reg_wr    = r_wr;
   assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: a bit-banged I2C master on a wired-AND SDA
// line plus a register file model that returns the inverted pointer.
module tb_i2c_reg_slave;

   localparam int QUARTER = 10;

   logic       clk;
   logic       reset;
   logic       sclDrv;
   logic       sdaDrv;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr;
   logic [7:0] reg_rdata;
   logic       busy;

   int         compareCount;
   int         mismatchCount;
   int         wrCount;
   int         wrLong;
   logic       prevWr;
   logic       busyEver;
   logic [7:0] wrAddrLog [8];
   logic [7:0] wrDataLog [8];

   i2c_reg_slave #(.SLAVE_ADDR(7'h1A)) dut (
      .clk       (clk),
      .reset     (reset),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .sda_oe    (sda_oe),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   assign scl_in    = sclDrv;
   assign sda_in    = sdaDrv & ~sda_oe;
   assign reg_rdata = ~reg_addr;

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Log every write strobe and flag any strobe wider than one clk
   always @(negedge clk) begin
      if (reg_wr) begin
         if (wrCount < 8) begin
            wrAddrLog[wrCount] = reg_addr;
            wrDataLog[wrCount] = reg_wdata;
         end
         wrCount++;
         if (prevWr) wrLong++;
      end
      prevWr = reg_wr;
      if (busy) busyEver = 1'b1;
   end

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %02h, expected %02h", tag, observed, expected);
      end
   endtask

   task automatic waitClks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCL period: drive SDA while low, sample the wired line mid-high
   task automatic applyStimulus(input logic bitVal, output logic sampled);
      sdaDrv = bitVal;
      waitClks(QUARTER);
      sclDrv = 1'b1;
      waitClks(QUARTER);
      sampled = sda_in;
      waitClks(QUARTER);
      sclDrv = 1'b0;
      waitClks(QUARTER);
   endtask

   task automatic sendStart();
      sdaDrv = 1'b1;
      waitClks(QUARTER);
      sclDrv = 1'b1;
      waitClks(QUARTER);
      sdaDrv = 1'b0;
      waitClks(QUARTER);
      sclDrv = 1'b0;
      waitClks(QUARTER);
   endtask

   task automatic sendStop();
      sdaDrv = 1'b0;
      waitClks(QUARTER);
      sclDrv = 1'b1;
      waitClks(QUARTER);
      sdaDrv = 1'b1;
      waitClks(QUARTER);
   endtask

   task automatic sendByte(input logic [7:0] data, output logic ack);
      logic dummy;
      for (int i = 7; i >= 0; i--) applyStimulus(data[i], dummy);
      applyStimulus(1'b1, ack);
   endtask

   task automatic recvByte(input logic masterAck, output logic [7:0] data);
      logic b;
      logic dummy;
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(1'b1, b);
         data[i] = b;
      end
      applyStimulus(masterAck, dummy);
   endtask

   initial begin
      logic       ack;
      logic       dummy;
      logic [7:0] rx;
      logic [7:0] pattern;
      compareCount  = 0;
      mismatchCount = 0;
      wrCount       = 0;
      wrLong        = 0;
      prevWr        = 1'b0;
      busyEver      = 1'b0;
      sclDrv        = 1'b1;
      sdaDrv        = 1'b1;
      reset         = 1'b1;
      waitClks(3);
      checkOutput("rstSdaOe", {7'd0, sda_oe}, 8'h00);
      checkOutput("rstWr", {7'd0, reg_wr}, 8'h00);
      checkOutput("rstBusy", {7'd0, busy}, 8'h00);
      checkOutput("rstAddr", reg_addr, 8'h00);
      checkOutput("rstWdata", reg_wdata, 8'h00);
      reset = 1'b0;
      waitClks(5);

      // Single write: ptr 0x1D, data 0x00
      sendStart();
      sendByte(8'h34, ack);
      checkOutput("w1DevAck", {7'd0, ack}, 8'h00);
      checkOutput("w1Busy", {7'd0, busy}, 8'h01);
      sendByte(8'h1D, ack);
      checkOutput("w1PtrAck", {7'd0, ack}, 8'h00);
      sendByte(8'h00, ack);
      checkOutput("w1DataAck", {7'd0, ack}, 8'h00);
      sendStop();
      waitClks(5);
      checkOutput("w1WrCount", wrCount[7:0], 8'd1);
      checkOutput("w1WrAddr", wrAddrLog[0], 8'h1D);
      checkOutput("w1WrData", wrDataLog[0], 8'h00);
      checkOutput("w1PtrAfter", reg_addr, 8'h1E);
      checkOutput("w1BusyStop", {7'd0, busy}, 8'h00);

      // Burst write across the pointer wrap
      wrCount = 0;
      sendStart();
      sendByte(8'h34, ack);
      sendByte(8'hFF, ack);
      sendByte(8'h11, ack);
      checkOutput("w2Data0Ack", {7'd0, ack}, 8'h00);
      sendByte(8'h22, ack);
      checkOutput("w2Data1Ack", {7'd0, ack}, 8'h00);
      sendStop();
      waitClks(5);
      checkOutput("w2WrCount", wrCount[7:0], 8'd2);
      checkOutput("w2WrAddr0", wrAddrLog[0], 8'hFF);
      checkOutput("w2WrData0", wrDataLog[0], 8'h11);
      checkOutput("w2WrAddr1", wrAddrLog[1], 8'h00);
      checkOutput("w2WrData1", wrDataLog[1], 8'h22);
      checkOutput("w2PtrAfter", reg_addr, 8'h01);

      // Foreign address 0x2B is ignored
      wrCount  = 0;
      busyEver = 1'b0;
      sendStart();
      sendByte(8'h56, ack);
      checkOutput("naAck", {7'd0, ack}, 8'h01);
      sendByte(8'h00, ack);
      sendStop();
      waitClks(5);
      checkOutput("naBusyEver", {7'd0, busyEver}, 8'h00);
      checkOutput("naWrCount", wrCount[7:0], 8'd0);
      checkOutput("naPtr", reg_addr, 8'h01);

      // Pointer write, repeated START, two-byte read
      wrCount = 0;
      sendStart();
      sendByte(8'h34, ack);
      sendByte(8'h04, ack);
      sendStart();
      sendByte(8'h35, ack);
      checkOutput("rdDevAck", {7'd0, ack}, 8'h00);
      recvByte(1'b0, rx);
      checkOutput("rdByte0", rx, 8'hFB);
      recvByte(1'b1, rx);
      checkOutput("rdByte1", rx, 8'hFA);
      checkOutput("rdSdaRel", {7'd0, sda_oe}, 8'h00);
      checkOutput("rdIdleBusy", {7'd0, busy}, 8'h00);
      checkOutput("rdPtr", reg_addr, 8'h05);
      sendStop();
      waitClks(5);
      checkOutput("rdWrCount", wrCount[7:0], 8'd0);

      // STOP half-way through a data byte, then a normal write
      sendStart();
      sendByte(8'h34, ack);
      sendByte(8'h40, ack);
      pattern = 8'hA0;
      for (int i = 7; i >= 4; i--) applyStimulus(pattern[i], dummy);
      sendStop();
      waitClks(5);
      checkOutput("abWrCount", wrCount[7:0], 8'd0);
      checkOutput("abBusy", {7'd0, busy}, 8'h00);
      checkOutput("abPtr", reg_addr, 8'h40);
      sendStart();
      sendByte(8'h34, ack);
      sendByte(8'h41, ack);
      sendByte(8'h5A, ack);
      checkOutput("abNextAck", {7'd0, ack}, 8'h00);
      sendStop();
      waitClks(5);
      checkOutput("abNextCount", wrCount[7:0], 8'd1);
      checkOutput("abNextAddr", wrAddrLog[0], 8'h41);
      checkOutput("abNextData", wrDataLog[0], 8'h5A);
      checkOutput("abNextPtr", reg_addr, 8'h42);

      // Reset while the slave drives a 0 read bit
      sendStart();
      sendByte(8'h34, ack);
      sendByte(8'h80, ack);
      sendStart();
      sendByte(8'h35, ack);
      checkOutput("rsDriving", {7'd0, sda_oe}, 8'h01);
      reset = 1'b1;
      #1;
      checkOutput("rsAsyncRel", {7'd0, sda_oe}, 8'h00);
      waitClks(3);
      reset = 1'b0;
      waitClks(3);
      busyEver = 1'b0;
      pattern = 8'h34;
      for (int i = 7; i >= 0; i--) applyStimulus(pattern[i], dummy);
      applyStimulus(1'b1, ack);
      checkOutput("rsNoStartAck", {7'd0, ack}, 8'h01);
      checkOutput("rsNoStartBusy", {7'd0, busyEver}, 8'h00);
      sendStop();
      sendStart();
      sendByte(8'h35, ack);
      checkOutput("rsFreshAck", {7'd0, ack}, 8'h00);
      recvByte(1'b1, rx);
      checkOutput("rsFreshByte", rx, 8'hFF);
      sendStop();
      waitClks(5);
      checkOutput("wrPulseWidth", wrLong[7:0], 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
